// File: rtl/sign_ext_pipe.sv
// sign_ext_pipe: registered immediate sign/zero extender with valid/ready and a 2-entry skid buffer
module sign_ext_pipe #(
    parameter int N  = 12,
    parameter int M  = 32,
    parameter int LW = $clog2(N + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [N-1:0]  i_imm,
    input  logic [LW-1:0] i_len,
    input  logic          i_zext,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [M-1:0]  o_ext_imm
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    if (N < 2 || M < N) begin : g_bad_cfg
        $error("sign_ext_pipe: invalid parameters (need N >= 2 and M >= N)");
    end

    logic [1:0]    state, next_state;
    logic [M-1:0]  skid, r, imm_m, mask;
    logic [LW-1:0] k;
    logic          acc, xfer, fill;

    assign acc     = i_valid & o_ready;
    assign xfer    = o_valid & i_ready;
    assign o_valid = state != EMPTY;

    // mask selects the k significant bits; everything above is replaced by the fill bit
    always_comb begin
        k     = (i_len == '0 || i_len > LW'(N)) ? LW'(N) : i_len;
        imm_m = M'(i_imm);
        mask  = (M'(1) << k) - M'(1);
        fill  = ~i_zext & |(imm_m & (M'(1) << (k - LW'(1))));
        r     = (imm_m & mask) | (~mask & {M{fill}});
    end

    always_comb begin
        next_state = state;
        if (state == EMPTY)
            next_state = acc ? ONE : EMPTY;
        else if (state == ONE)
            next_state = (acc & ~xfer) ? TWO : (~acc & xfer) ? EMPTY : ONE;
        else
            next_state = xfer ? ONE : TWO;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= EMPTY;
            o_ready   <= 1'b0;
            o_ext_imm <= '0;
            skid      <= '0;
        end else begin
            state   <= next_state;
            o_ready <= next_state != TWO;
            if ((state == EMPTY && acc) || (state == ONE && acc && xfer))
                o_ext_imm <= r;
            else if (state == TWO && xfer)
                o_ext_imm <= skid;
            if (state == ONE && acc && !xfer)
                skid <= r;
        end
    end
endmodule

// File: tb/tb_sign_ext_pipe.sv
// tb_sign_ext_pipe: directed table, corner sequences and random scoreboard for sign_ext_pipe
module tb_sign_ext_pipe;
    localparam int N  = 12;
    localparam int M  = 32;
    localparam int LW = $clog2(N + 1);

    logic          clk = 0, rst = 1, i_valid = 0, i_ready = 0, i_zext = 0;
    logic [N-1:0]  i_imm = '0;
    logic [LW-1:0] i_len = '0;
    logic          o_ready, o_valid;
    logic [M-1:0]  o_ext_imm;

    sign_ext_pipe #(.N(N), .M(M)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_imm(i_imm), .i_len(i_len), .i_zext(i_zext),
        .o_valid(o_valid), .i_ready(i_ready), .o_ext_imm(o_ext_imm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  imm;
        logic [LW-1:0] len;
        bit            zext;
        logic [M-1:0]  exp;
    } vec_t;

    int           checks = 0, errors = 0, n_acc = 0;
    logic [M-1:0] sb[$];
    logic         prev_stall = 0;
    logic [M-1:0] prev_val = '0;
    vec_t         vecs[8];
    logic [N-1:0] seq[3];

    // plain arithmetic reference: keep k bits, then reinterpret as signed if sign-extending
    function automatic logic [M-1:0] model(logic [N-1:0] imm, int len, bit zext);
        int    kk = (len == 0 || len > N) ? N : len;
        longint v = longint'(imm) % (longint'(1) << kk);
        if (!zext && v >= (longint'(1) << (kk - 1)))
            v -= longint'(1) << kk;
        return M'(v);
    endfunction

    task automatic chk(string name, logic [M-1:0] act, logic [M-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid", M'(o_valid), M'(1));
            chk("stall_data", o_ext_imm, prev_val);
        end
        if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_output: got %h expected no output at %0t", o_ext_imm, $time);
            end else
                chk("order", o_ext_imm, sb.pop_front());
        end
        if (i_valid && o_ready) begin
            sb.push_back(model(i_imm, int'(i_len), i_zext));
            n_acc++;
        end
        prev_stall = o_valid && !i_ready;
        prev_val   = o_ext_imm;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{12'hFF6, 4'd0,  1'b0, 32'hFFFFFFF6};
        vecs[1] = '{12'hFF6, 4'd0,  1'b1, 32'h00000FF6};
        vecs[2] = '{12'h0A5, 4'd5,  1'b0, 32'h00000005};
        vecs[3] = '{12'h0A5, 4'd6,  1'b0, 32'hFFFFFFE5};
        vecs[4] = '{12'h0A5, 4'd15, 1'b0, 32'h000000A5};
        vecs[5] = '{12'h800, 4'd12, 1'b0, 32'hFFFFF800};
        vecs[6] = '{12'h7FF, 4'd12, 1'b0, 32'h000007FF};
        vecs[7] = '{12'h001, 4'd1,  1'b0, 32'hFFFFFFFF};
        seq[0] = 12'h123; seq[1] = 12'h9AB; seq[2] = 12'hF0F;

        #1;
        chk("reset_valid", M'(o_valid), '0);
        chk("reset_ready", M'(o_ready), '0);
        chk("reset_data", o_ext_imm, '0);
        @(posedge clk); #1;
        rst = 0;
        chk("ready_before_edge", M'(o_ready), '0);
        cycle();
        chk("ready_after_edge", M'(o_ready), M'(1));

        // directed table, one request at a time
        i_ready = 1;
        foreach (vecs[i]) begin
            i_valid = 1; i_imm = vecs[i].imm; i_len = vecs[i].len; i_zext = vecs[i].zext;
            cycle();
            i_valid = 0;
            chk("vec_valid", M'(o_valid), M'(1));
            chk($sformatf("vec%0d", i), o_ext_imm, vecs[i].exp);
            cycle();
        end

        // full-throughput sweep
        i_valid = 1;
        for (int i = 0; i < 5000; i++) begin
            i_imm  = N'(i - 10);
            i_len  = LW'($urandom_range(0, 15));
            i_zext = 1'($urandom);
            if (i > 0) chk("sweep_ready", M'(o_ready), M'(1));
            cycle();
        end
        i_valid = 0;
        repeat (3) cycle();
        chk("sweep_drain", M'(sb.size()), '0);

        // backpressure fills OUT and SKID, third request is refused
        i_ready = 0; i_valid = 1; i_len = 0; i_zext = 0;
        i_imm = seq[0]; cycle();
        i_imm = seq[1]; cycle();
        i_imm = seq[2];
        chk("full_ready", M'(o_ready), '0);
        chk("full_out", o_ext_imm, model(seq[0], 0, 0));
        cycle();
        chk("held_out", o_ext_imm, model(seq[0], 0, 0));
        i_ready = 1;
        cycle();
        chk("emit_b", o_ext_imm, model(seq[1], 0, 0));
        cycle();
        i_valid = 0;
        chk("emit_c", o_ext_imm, model(seq[2], 0, 0));
        cycle();
        chk("after_abc_valid", M'(o_valid), '0);
        chk("abc_drain", M'(sb.size()), '0);

        // async reset while two entries are held
        i_ready = 0; i_valid = 1; i_imm = 12'h555; cycle(); i_imm = 12'hAAA; cycle();
        i_valid = 0;
        chk("pre_reset_full", M'(o_ready), '0);
        #2 rst = 1;
        #1;
        chk("areset_valid", M'(o_valid), '0);
        chk("areset_ready", M'(o_ready), '0);
        chk("areset_data", o_ext_imm, '0);
        sb.delete();
        prev_stall = 0;
        @(posedge clk); #1;
        rst = 0;
        i_ready = 1;
        cycle();
        i_valid = 1; i_imm = 12'h8F0; i_len = 4'd8; i_zext = 0;
        cycle();
        i_valid = 0;
        chk("post_reset_valid", M'(o_valid), M'(1));
        chk("post_reset_data", o_ext_imm, 32'hFFFFFFF0);
        cycle();

        // random handshakes against the scoreboard
        n_acc = 0;
        for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
            i_valid = 1'($urandom);
            i_ready = 1'($urandom);
            i_imm   = N'($urandom);
            i_len   = LW'($urandom_range(0, 15));
            i_zext  = 1'($urandom);
            cycle();
        end
        chk("random_requests", M'(n_acc), M'(10000));
        i_valid = 0; i_ready = 1;
        repeat (4) cycle();
        chk("random_drain", M'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
